// File: rtl/svc_axi_axil_reflect_wr.sv
// AXI (single-beat) to AXI-Lite write bridge; {awid, awuser} queued and reflected on B.
// Optional sticky protocol-error flag when SVC_AXI_AXIL_REFLECT_WR_ERR_EN is defined.

module svc_axi_axil_reflect_wr_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full_n,
    input  logic             i_pop,
    output logic             o_empty_n,
    output logic [WIDTH-1:0] o_rdata
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic              r_full_n;
    logic              r_empty_n;
    logic              w_push;
    logic              w_pop;

    assign w_push = i_push && r_full_n;
    assign w_pop  = i_pop && r_empty_n;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    // Flags are derived from the next count so ready/valid never bypass the storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_full_n  <= 1'b0;
            r_empty_n <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_full_n  <= (w_cnt_nxt != DEPTH_C);
            r_empty_n <= (w_cnt_nxt != '0);
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_full_n  = r_full_n;
    assign o_empty_n = r_empty_n;
    assign o_rdata   = r_mem[r_rptr];
endmodule

module svc_axi_axil_reflect_wr #(
    parameter int AXI_ADDR_WIDTH           = 8,
    parameter int AXI_DATA_WIDTH           = 16,
    parameter int AXI_ID_WIDTH             = 4,
    parameter int AXI_USER_WIDTH           = 1,
    parameter int OUTSTANDING_WRITES_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          s_axi_awvalid,
    input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [2:0]                    s_axi_awsize,
    input  logic [1:0]                    s_axi_awburst,
    input  logic [AXI_USER_WIDTH-1:0]     s_axi_awuser,
    output logic                          s_axi_awready,
    input  logic                          s_axi_wvalid,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                          s_axi_wlast,
    output logic                          s_axi_wready,
    output logic                          s_axi_bvalid,
    output logic [AXI_ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                    s_axi_bresp,
    output logic [AXI_USER_WIDTH-1:0]     s_axi_buser,
    input  logic                          s_axi_bready,

    output logic                          m_axil_awvalid,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axil_awaddr,
    input  logic                          m_axil_awready,
    output logic                          m_axil_wvalid,
    output logic [AXI_DATA_WIDTH-1:0]     m_axil_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axil_wstrb,
    input  logic                          m_axil_wready,
    input  logic                          m_axil_bvalid,
    input  logic [1:0]                    m_axil_bresp,
    output logic                          m_axil_bready
`ifdef SVC_AXI_AXIL_REFLECT_WR_ERR_EN
    ,
    output logic                          err
`endif
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int IDQ_W  = AXI_ID_WIDTH + AXI_USER_WIDTH;
    localparam int WQ_W   = AXI_DATA_WIDTH + STRB_W;

    logic w_aw_full_n;
    logic w_aw_empty_n;
    logic w_id_full_n;
    logic w_id_empty_n;
    logic w_w_full_n;
    logic w_w_empty_n;
    logic w_aw_push;
    logic w_w_push;
    logic w_b_pop;

    // One AW handshake feeds both the address queue and the ID queue.
    assign s_axi_awready = w_aw_full_n && w_id_full_n;
    assign w_aw_push     = s_axi_awvalid && s_axi_awready;
    assign s_axi_wready  = w_w_full_n;
    assign w_w_push      = s_axi_wvalid && s_axi_wready;
    assign w_b_pop       = m_axil_bvalid && s_axi_bready;

    svc_axi_axil_reflect_wr_fifo #(
        .WIDTH  (AXI_ADDR_WIDTH),
        .ADDR_W (1)
    ) u_aw_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_aw_push),
        .i_wdata   (s_axi_awaddr),
        .o_full_n  (w_aw_full_n),
        .i_pop     (m_axil_awvalid && m_axil_awready),
        .o_empty_n (w_aw_empty_n),
        .o_rdata   (m_axil_awaddr)
    );

    svc_axi_axil_reflect_wr_fifo #(
        .WIDTH  (IDQ_W),
        .ADDR_W (OUTSTANDING_WRITES_WIDTH)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_aw_push),
        .i_wdata   ({s_axi_awid, s_axi_awuser}),
        .o_full_n  (w_id_full_n),
        .i_pop     (w_b_pop),
        .o_empty_n (w_id_empty_n),
        .o_rdata   ({s_axi_bid, s_axi_buser})
    );

    svc_axi_axil_reflect_wr_fifo #(
        .WIDTH  (WQ_W),
        .ADDR_W (1)
    ) u_w_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_w_push),
        .i_wdata   ({s_axi_wdata, s_axi_wstrb}),
        .o_full_n  (w_w_full_n),
        .i_pop     (m_axil_wvalid && m_axil_wready),
        .o_empty_n (w_w_empty_n),
        .o_rdata   ({m_axil_wdata, m_axil_wstrb})
    );

    assign m_axil_awvalid = w_aw_empty_n;
    assign m_axil_wvalid  = w_w_empty_n;

    // AXI-Lite B returns in order, so the ID queue head always matches it.
    assign s_axi_bvalid  = m_axil_bvalid;
    assign s_axi_bresp   = m_axil_bresp;
    assign m_axil_bready = s_axi_bready;

`ifdef SVC_AXI_AXIL_REFLECT_WR_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((w_aw_push && (s_axi_awlen != 8'd0)) || (w_w_push && !s_axi_wlast)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    logic w_unused;
    assign w_unused = ^{s_axi_awsize, s_axi_awburst, w_id_empty_n};
`else
    logic w_unused;
    assign w_unused = ^{s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_wlast, w_id_empty_n};
`endif
endmodule
